ram_port_arbiter: RTL and testbench

Two-requester arbiter that shares a single port of the 16-bit dual-port datapath RAM between two masters, e.g. the datapath controller and a load/debug engine. It accepts one request at a time through a req/ack handshake and drives the RAM port's address, data and write-enable. It waits out the RAM read latency, then returns read data with a one-cycle ack. It sits directly in front of the memory wrapper's port A (or B); the other RAM port is untouched.

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/ram_arb_pick.sv | 50 +++++
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Snapshot of the arbiter FSM for checkers and waveform probes.
  typedef struct packed {
    arb_state_e state;
    logic [1:0] lat_cnt;
    logic       grant;
  } arb_dbg_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for the RAM port arbiter. ARB_ROUND_ROBIN_EN selects
// round-robin with a registered pointer; otherwise requester 0 wins ties.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_i,
  output logic winner_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic pref_q, pref_d;

  // pref_q names the requester that wins a tie: the one not granted last.
  always_comb begin
    winner_o = REQ0;
    if (req0_i && req1_i) begin
      winner_o = pref_q;
    end else if (req1_i) begin
      winner_o = REQ1;
    end
    pref_d = pref_q;
    if (grant_i) begin
      pref_d = ~winner_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pref_q <= REQ0;
    end else begin
      pref_q <= pref_d;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = clk_i ^ rst_i ^ grant_i;

  always_comb begin
    winner_o = REQ0;
    if (!req0_i && req1_i) begin
      winner_o = REQ1;
    end
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between two req/ack masters. Tie policy is set by
// ARB_ROUND_ROBIN_EN (round-robin when defined, fixed priority otherwise).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_wren,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_wren,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              mwren_q, mwren_d;
  logic              wr_op_q, wr_op_d;
  logic              grant_q, grant_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              take, winner;
  arb_dbg_t          dbg_unused;

  assign take = (state_q == IDLE) && (r0_req || r1_req);

  ram_arb_pick u_pick (
    .clk_i    (clock),
    .rst_i    (reset),
    .req0_i   (r0_req),
    .req1_i   (r1_req),
    .grant_i  (take),
    .winner_o (winner)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    wr_op_d  = wr_op_q;
    grant_d  = grant_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mwren_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = ISSUE;
          grant_d = winner;
          if (winner == REQ1) begin
            maddr_d = r1_addr;
            mdata_d = r1_wdata;
            wr_op_d = r1_wren;
          end else begin
            maddr_d = r0_addr;
            mdata_d = r0_wdata;
            wr_op_d = r0_wren;
          end
          mwren_d = wr_op_d;
        end
      end
      ISSUE: begin
        if (wr_op_q) begin
          state_d = RESP;
          ack0_d  = (grant_q == REQ0);
          ack1_d  = (grant_q == REQ1);
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_INIT;
        end
      end
      WAIT: begin
        // Counter reaching zero marks the cycle in which mem_q is valid.
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          ack0_d  = (grant_q == REQ0);
          ack1_d  = (grant_q == REQ1);
          if (grant_q == REQ1) begin
            rdata1_d = mem_q;
          end else begin
            rdata0_d = mem_q;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      wr_op_q  <= 1'b0;
      grant_q  <= REQ0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mwren_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      wr_op_q  <= wr_op_d;
      grant_q  <= grant_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mwren_q  <= mwren_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  // Probe point so checkers can bind to the FSM without extra ports.
  assign dbg_unused = '{state: state_q, lat_cnt: cnt_q, grant: grant_q};

  assign mem_address = maddr_q;
  assign mem_data    = mdata_q;
  assign mem_wren    = mwren_q;
  assign r0_ack      = ack0_q;
  assign r1_ack      = ack1_q;
  assign r0_rdata    = rdata0_q;
  assign r1_rdata    = rdata1_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, corner
// sequences, an RD_LAT=3 instance and randomized traffic against a memory model.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic ram_init;
  always #5 clock = ~clock;

  // ---------------- DUT A (RD_LAT=1) ----------------
  logic        r0_req, r0_wren, r0_ack, r1_req, r1_wren, r1_ack;
  logic [15:0] r0_addr, r0_wdata, r0_rdata, r1_addr, r1_wdata, r1_rdata;
  logic [15:0] mem_address, mem_data, mem_q;
  logic        mem_wren, busy, grant_id;

  ram_port_arbiter #(.RD_LAT(1)) u_a (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wren(r0_wren),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wren(r1_wren),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .grant_id(grant_id)
  );

  // ---------------- DUT B (RD_LAT=3, requester 1 idle) ----------------
  logic        b_req, b_wren, b_ack, b_r1_ack, b_mem_wren, b_busy, b_grant;
  logic [15:0] b_addr, b_wdata, b_rdata, b_r1_rdata, b_mem_address, b_mem_data, b_mem_q;
  logic        b_r1_req = 1'b0;
  logic        b_r1_wren = 1'b0;
  logic [15:0] b_r1_addr = 16'h0;
  logic [15:0] b_r1_wdata = 16'h0;

  ram_port_arbiter #(.RD_LAT(3)) u_b (
    .clock(clock), .reset(reset),
    .r0_req(b_req), .r0_addr(b_addr), .r0_wdata(b_wdata), .r0_wren(b_wren),
    .r0_ack(b_ack), .r0_rdata(b_rdata),
    .r1_req(b_r1_req), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata), .r1_wren(b_r1_wren),
    .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .mem_address(b_mem_address), .mem_data(b_mem_data), .mem_wren(b_mem_wren),
    .mem_q(b_mem_q), .busy(b_busy), .grant_id(b_grant)
  );

  // ---------------- RAM models (256 words, low address byte) ----------------
  function automatic logic [15:0] init_word(input logic [7:0] a);
    return {8'hC3, a};
  endfunction

  logic [15:0] ram_a [256];
  logic [15:0] ram_b [256];
  logic [15:0] b_p0, b_p1;

  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_a[i] <= init_word(i[7:0]);
    end else if (mem_wren) begin
      ram_a[mem_address[7:0]] <= mem_data;
    end
    mem_q <= ram_a[mem_address[7:0]];
  end

  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_b[i] <= (i == 'h42) ? 16'h1234 : init_word(i[7:0]);
    end else if (b_mem_wren) begin
      ram_b[b_mem_address[7:0]] <= b_mem_data;
    end
    b_p0    <= ram_b[b_mem_address[7:0]];
    b_p1    <= b_p0;
    b_mem_q <= b_p1;
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          wr_pulses = 0;
  logic [15:0] model_mem [256];
  logic [15:0] exp_rd [2];
  logic [16:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every write pulse must carry the granted requester's own fields.
  always @(negedge clock) begin
    if (!reset && mem_wren) begin
      wr_pulses++;
      if (grant_id == REQ1) begin
        chk("wr_addr1", 32'(mem_address), 32'(r1_addr));
        chk("wr_data1", 32'(mem_data), 32'(r1_wdata));
        chk("wr_owner1", 32'(r1_req & r1_wren), 32'd1);
      end else begin
        chk("wr_addr0", 32'(mem_address), 32'(r0_addr));
        chk("wr_data0", 32'(mem_data), 32'(r0_wdata));
        chk("wr_owner0", 32'(r0_req & r0_wren), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic who, input logic wren, input logic [15:0] addr,
                       input logic [15:0] wdata);
    if (who == REQ1) begin
      r1_req = 1'b1; r1_wren = wren; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_req = 1'b1; r0_wren = wren; r0_addr = addr; r0_wdata = wdata;
    end
  endtask

  task automatic drop(input logic who);
    if (who == REQ1) r1_req = 1'b0;
    else r0_req = 1'b0;
  endtask

  function automatic logic ack_of(input logic who);
    return (who == REQ1) ? r1_ack : r0_ack;
  endfunction

  function automatic logic [15:0] rdata_of(input logic who);
    return (who == REQ1) ? r1_rdata : r0_rdata;
  endfunction

  // Called on the ack cycle: apply the transaction to the memory model and
  // check both read-data registers plus the grant.
  task automatic complete(input logic who, input logic wren, input logic [15:0] addr,
                          input logic [15:0] wdata);
    if (wren) model_mem[addr[7:0]] = wdata;
    else exp_rd[who] = model_mem[addr[7:0]];
    chk("rdata0", 32'(r0_rdata), 32'(exp_rd[0]));
    chk("rdata1", 32'(r1_rdata), 32'(exp_rd[1]));
    chk("grant_id", 32'(grant_id), 32'(who));
  endtask

  task automatic do_txn(input logic who, input logic wren, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output int pulses);
    int w0;
    @(negedge clock);
    drive(who, wren, addr, wdata);
    w0 = wr_pulses;
    lat = 0;
    while (!ack_of(who) && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (!ack_of(who)) chk("txn_timeout", 32'd0, 32'd1);
    else complete(who, wren, addr, wdata);
    pulses = wr_pulses - w0;
    drop(who);
  endtask

  task automatic sb_pop(input string name, input logic [16:0] got);
    logic [16:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1FFFF;
    chk(name, 32'(got), 32'(e));
    exp_rd[got[16]] = e[15:0];
  endtask

  task automatic rand_driver(input logic who, input int n, output int done);
    int gap, waited;
    logic wren;
    logic [15:0] addr, wdata;
    done = 0;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0 || k == 0) begin
        drop(who);
        repeat (gap + 1) @(negedge clock);
      end
      wren  = 1'($urandom_range(0, 1));
      addr  = {8'($urandom), 5'd0, 3'($urandom_range(0, 7))};
      wdata = 16'($urandom);
      drive(who, wren, addr, wdata);
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!ack_of(who) && waited < 200);
      if (!ack_of(who)) begin
        chk("rand_timeout", 32'd0, 32'd1);
        break;
      end
      complete(who, wren, addr, wdata);
      done++;
    end
    drop(who);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        who;
    logic        wren;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, pulses, left0, left1, k0, k1, acks, waits, ack2_at;
    int done0, done1;

    reset = 1'b1; ram_init = 1'b1;
    r0_req = 0; r0_wren = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_wren = 0; r1_addr = 0; r1_wdata = 0;
    b_req = 0; b_wren = 0; b_addr = 0; b_wdata = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i[7:0]);
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;

    vecs[0] = '{REQ0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 2};
    vecs[1] = '{REQ0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3};
    vecs[2] = '{REQ1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 2};
    vecs[3] = '{REQ1, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 3};
    vecs[4] = '{REQ0, 1'b1, 16'h0000, 16'hA5A5, 16'h0000, 2};
    vecs[5] = '{REQ1, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 3};
    vecs[6] = '{REQ0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 3};
    vecs[7] = '{REQ1, 1'b0, 16'h0020, 16'h0000, 16'hC320, 3};

    repeat (3) @(posedge clock);
    @(negedge clock);
    ram_init = 1'b0; reset = 1'b0;

    // Reset values
    @(negedge clock);
    chk("rst_outputs", 32'({r0_ack, r1_ack, mem_wren, busy, grant_id}), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);

    // Table: single transactions, latency and write-pulse count
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].who, vecs[i].wren, vecs[i].addr, vecs[i].wdata, lat, pulses);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("tbl%0d_pulses", i), 32'(pulses), vecs[i].wren ? 32'd1 : 32'd0);
      if (!vecs[i].wren)
        chk($sformatf("tbl%0d_rdata", i), 32'(rdata_of(vecs[i].who)), 32'(vecs[i].exp_rdata));
    end

    // Simultaneous reads: r0 wants two reads, r1 one, both held from the same cycle
    exp_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back({REQ0, 16'hC330});
    exp_q.push_back({REQ1, 16'hC331});
    exp_q.push_back({REQ0, 16'hC330});
`else
    exp_q.push_back({REQ0, 16'hC330});
    exp_q.push_back({REQ0, 16'hC330});
    exp_q.push_back({REQ1, 16'hC331});
`endif
    @(negedge clock);
    drive(REQ0, 1'b0, 16'h0030, 16'h0);
    drive(REQ1, 1'b0, 16'h0031, 16'h0);
    left0 = 2; left1 = 1;
    for (int k = 0; k < 80 && (left0 > 0 || left1 > 0); k++) begin
      @(negedge clock);
      if (r0_ack && left0 > 0) begin
        sb_pop("sim_order", {REQ0, r0_rdata});
        left0--;
        if (left0 == 0) drop(REQ0);
      end
      if (r1_ack && left1 > 0) begin
        sb_pop("sim_order", {REQ1, r1_rdata});
        left1--;
        if (left1 == 0) drop(REQ1);
      end
    end
    chk("sim_all_served", 32'(left0 + left1), 32'd0);
    chk("sim_queue_empty", 32'(exp_q.size()), 32'd0);

    // Request during busy: r1 arrives while r0's read sits in WAIT
    @(negedge clock);
    drive(REQ0, 1'b0, 16'h0040, 16'h0);
    k0 = -1; k1 = -1;
    for (int k = 1; k < 40 && k1 < 0; k++) begin
      @(negedge clock);
      if (k == 2) drive(REQ1, 1'b0, 16'h0041, 16'h0);
      if (r0_ack) begin k0 = k; complete(REQ0, 1'b0, 16'h0040, 16'h0); drop(REQ0); end
      if (r1_ack) begin k1 = k; complete(REQ1, 1'b0, 16'h0041, 16'h0); drop(REQ1); end
    end
    chk("busy_r0_ack_at", 32'(k0), 32'd3);
    chk("busy_r1_ack_at", 32'(k1), 32'd7);
    chk("busy_r0_rdata_kept", 32'(r0_rdata), 32'h0000C340);

    // Held request after ack: exactly two identical writes
    @(negedge clock);
    drive(REQ0, 1'b1, 16'h0050, 16'h7777);
    k0 = wr_pulses; acks = 0; ack2_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (r0_ack) begin
        acks++;
        complete(REQ0, 1'b1, 16'h0050, 16'h7777);
        if (acks == 2) begin ack2_at = k; drop(REQ0); end
      end
    end
    chk("held_acks", 32'(acks), 32'd2);
    chk("held_second_ack_at", 32'(ack2_at), 32'd5);
    chk("held_pulses", 32'(wr_pulses - k0), 32'd2);

    // RD_LAT=3 instance: preloaded 0x1234 at 0x0042
    @(negedge clock);
    b_req = 1'b1; b_wren = 1'b0; b_addr = 16'h0042;
    lat = 0; waits = 0;
    while (!b_ack && lat < 30) begin
      @(negedge clock);
      lat++;
      if (u_b.dbg_unused.state == WAIT) waits++;
    end
    b_req = 1'b0;
    chk("lat3_ack_at", 32'(lat), 32'd5);
    chk("lat3_wait_cycles", 32'(waits), 32'd3);
    chk("lat3_rdata", 32'(b_rdata), 32'h00001234);

    // Reset during WAIT of a read
    @(negedge clock);
    drive(REQ0, 1'b0, 16'h0060, 16'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstw_flags", 32'({r0_ack, r1_ack, mem_wren, busy, grant_id}), 32'd0);
    chk("rstw_mem", 32'({mem_address, mem_data}), 32'd0);
    chk("rstw_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
    reset = 1'b0;
    drop(REQ0);
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (r0_ack || r1_ack) acks++;
    end
    chk("rstw_no_ack", 32'(acks), 32'd0);
    do_txn(REQ1, 1'b0, 16'h0061, 16'h0, lat, pulses);
    chk("rstw_after_lat", 32'(lat), 32'd3);
    chk("rstw_after_rdata", 32'(r1_rdata), 32'h0000C361);

    // Randomized concurrent traffic against the memory model
    fork
      rand_driver(REQ0, 40, done0);
      rand_driver(REQ1, 40, done1);
    join
    chk("rand_done0", 32'(done0), 32'd40);
    chk("rand_done1", 32'(done1), 32'd40);
    repeat (3) @(negedge clock);
    chk("rand_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
